// File: rtl/decouple_arb_pkg.sv
// Shared types and helpers for the round-robin decoupled arbiter:
// the lock FSM state type, the round-robin pick function and index-width math.
package decouple_arb_pkg;

    localparam int MAX_NUM = 32;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic        found;
        logic [31:0] idx;
    } rr_pick_t;

    function automatic int idx_width(input int num);
        return (num <= 2) ? 1 : $clog2(num);
    endfunction

    // First valid requester scanning ptr, ptr+1, ... and wrapping at num.
    function automatic rr_pick_t rr_pick(input logic [MAX_NUM-1:0] valid,
                                         input int ptr,
                                         input int num);
        rr_pick_t r;
        int       cand;
        r.found = 1'b0;
        r.idx   = '0;
        for (int o = 0; o < MAX_NUM; o++) begin
            if (o < num && !r.found) begin
                cand = ptr + o;
                if (cand >= num)
                    cand = cand - num;
                if (valid[cand[4:0]]) begin
                    r.found = 1'b1;
                    r.idx   = cand;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/decouple_fifo.sv
// Decoupling FIFO with valid/ready on both sides; din_ready is a pure full flag
// so it never depends on dout_ready. INIT_VALID preloads one zero word on reset.
module decouple_fifo #(
    parameter int DIN        = 8,
    parameter int DEPTH      = 2,
    parameter int INIT_VALID = 0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           din_valid,
    output logic           din_ready,
    input  logic [DIN-1:0] din_data,
    output logic           dout_valid,
    input  logic           dout_ready,
    output logic [DIN-1:0] dout_data
);

    localparam int AW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);

    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic [DIN-1:0] mem [DEPTH];
    logic           wr_en;
    logic           rd_en;
    logic           full;
    logic           empty;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign din_ready  = ~full;
    assign dout_valid = ~empty;
    assign dout_data  = mem[rd_ptr[AW-1:0]];
    assign wr_en      = din_valid & ~full;
    assign rd_en      = dout_ready & ~empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= (INIT_VALID != 0) ? (AW+1)'(1) : '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= din_data;
        end
    end

endmodule

// File: rtl/decouple_rr_arbiter.sv
// Round-robin arbiter sharing one decoupled output FIFO between NUM valid/ready
// streams; words are tagged with their source index, optional eot-based locking.
module decouple_rr_arbiter
    import decouple_arb_pkg::*;
#(
    parameter int NUM   = 4,
    parameter int DIN   = 16,
    parameter int DEPTH = 2,
    parameter int LOCK  = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM-1:0]                   din_valid,
    output logic [NUM-1:0]                   din_ready,
    input  logic [NUM*DIN-1:0]               din_data,
    output logic                             dout_valid,
    input  logic                             dout_ready,
    output logic [DIN+idx_width(NUM)-1:0]    dout_data
);

    localparam int IW = idx_width(NUM);

    arb_state_t           state;
    logic [IW-1:0]        ptr;
    logic [IW-1:0]        lock_idx;
    logic [IW-1:0]        sel;
    logic [IW-1:0]        next_ptr;
    logic [MAX_NUM-1:0]   valid_ext;
    rr_pick_t             pick;
    logic                 grant_valid;
    logic                 fifo_in_ready;
    logic                 full;
    logic                 push;
    logic                 release_grant;
    logic [DIN-1:0]       push_word;

    assign full = ~fifo_in_ready;

    // A locked stream keeps its ready even while it has no valid word.
    always_comb begin
        valid_ext            = '0;
        valid_ext[NUM-1:0]   = din_valid;
        pick                 = rr_pick(valid_ext, int'(ptr), NUM);
        if (state == ARB_LOCKED) begin
            sel         = lock_idx;
            grant_valid = 1'b1;
        end else begin
            sel         = IW'(pick.idx);
            grant_valid = pick.found;
        end
        din_ready = '0;
        if (rst && grant_valid && !full)
            din_ready[sel] = 1'b1;
    end

    assign push          = |(din_valid & din_ready);
    assign push_word     = din_data[int'(sel)*DIN +: DIN];
    assign release_grant = (LOCK == 0) || push_word[DIN-1];
    assign next_ptr      = (sel == IW'(NUM-1)) ? '0 : sel + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr      <= '0;
            state    <= ARB_IDLE;
            lock_idx <= '0;
        end else if (push) begin
            if (release_grant) begin
                ptr   <= next_ptr;
                state <= ARB_IDLE;
            end else begin
                lock_idx <= sel;
                state    <= ARB_LOCKED;
            end
        end
    end

    decouple_fifo #(
        .DIN        (DIN + IW),
        .DEPTH      (DEPTH),
        .INIT_VALID (0)
    ) u_fifo (
        .clk        (clk),
        .reset      (~rst),
        .din_valid  (push),
        .din_ready  (fifo_in_ready),
        .din_data   ({sel, push_word}),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_data  (dout_data)
    );

endmodule
